fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction prefetch queue sitting directly upstream of the instruction-decode stage, replacing the single-register fetch path. Issues sequential word fetches to instruction memory ahead of demand, buffers in-order responses with their PCs in a small FIFO, and presents them to decode under a valid/ready handshake. On a branch redirect from the memory stage it flushes buffered and in-flight instructions and restarts fetching at the target.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, 2..16
- XLEN, 32, instruction/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid (in order, latency ≥1)
- imem_rsp_data  in  XLEN  fetched instruction
- redirect  in  1  taken branch; flush and refetch
- redirect_pc  in  XLEN  branch target
- deq_valid  out  1  head instruction valid to decode
- deq_ready  in  1  decode consumes head (IF/ID load enable)
- deq_instr  out  XLEN  head instruction; NOP (32'h0000_0013) when empty
- deq_pc  out  XLEN  PC of head instruction

## Operation
- State: fetch_pc, FIFO (count 0..DEPTH), inflight counter (0..DEPTH), drop counter (0..DEPTH).
- Issue: imem_req_valid = 1 when count + inflight < DEPTH and redirect = 0. Request accepted when valid & ready: fetch_pc += 4, inflight += 1. Address held stable while valid & !ready.
- Response: imem_rsp_valid decrements inflight. If drop > 0, response discarded and drop -= 1; otherwise pushed to FIFO with its PC (tracked by rsp_pc register advanced +4 per kept response).
- Dequeue: deq_valid = (count > 0) & !redirect; pop on deq_valid & deq_ready.
- Redirect (one-cycle pulse): FIFO emptied; fetch_pc and rsp_pc := {redirect_pc[XLEN-1:2], 2'b00}; drop := inflight after this cycle's response; no request issued, no pop in that cycle; a response arriving in that cycle is discarded.
- Simultaneous push and pop with count = DEPTH is impossible by credit rule; push and pop same cycle keeps count unchanged.
- Credit rule counts dropped in-flight requests, so FIFO never overflows; no back-pressure on imem_rsp is needed.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, deq_valid 0, deq_instr NOP, deq_pc 0; fetch_pc = rsp_pc = RESET_PC; count, inflight, drop = 0.
- First cycle after reset release: imem_req_valid = 1, addr = RESET_PC.
- Response-to-deq_valid latency: 1 cycle (registered FIFO).
- Redirect at cycle N: cycle N+1 issues redirect_pc; earliest deq_valid for target at N+1+mem_latency+1.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses after release are not expected (memory is reset too).

## Configuration
- PREFETCH_BYPASS_EN defined: when FIFO is empty, drop = 0, redirect = 0 and imem_rsp_valid = 1, response drives deq_valid/deq_instr/deq_pc combinationally the same cycle; if deq_ready = 1 it is not written to the FIFO. Response-to-decode latency 0.
- Undefined: all responses pass through the FIFO; latency 1 cycle.

## Structure
- Shared package riscv_pkg: XLEN, NOP encoding 32'h0000_0013, RESET_PC default, instruction-word alignment constant (4).
- One sub-module, fetch_fifo: synchronous FIFO of {pc, instr}, DEPTH entries, push/pop/flush, count output, asynchronous active-low reset.
- Top holds fetch_pc, inflight/drop counters, issue logic and optional bypass.

## Test plan
- Reset release, memory latency 1, deq_ready = 1 -> requests at 0x0,0x4,0x8...; deq_pc 0x0 with its instr 2 cycles after first request, one instruction per cycle thereafter.
- deq_ready = 0 held -> exactly DEPTH (4) requests issued, FIFO full, imem_req_valid stays 0 until one pop.
- imem_req_ready low 3 cycles -> imem_req_addr held at 0x8, no duplicate/skipped PCs at decode.
- Latency 3, redirect to 0x100 with 2 requests in flight -> both stale responses dropped, next deq_pc = 0x100, no stale instruction ever has deq_valid.
- redirect_pc = 0x103 with simultaneous imem_rsp_valid and deq_ready -> response dropped, no pop, next request addr 0x100.
- Empty queue, latency 1 -> with PREFETCH_BYPASS_EN deq_valid in response cycle; without, one cycle later.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants for the fetch path: data width, NOP encoding,
// default reset PC and the instruction-word alignment.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSTR_ALIGN      = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} pairs with push/pop/flush and an occupancy
// count; DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    logic [2*XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is nonzero.
    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= {push_pc, push_instr};
    end

    assign {head_pc, head_instr} = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue ahead of decode with redirect flush.
// Optional same-cycle response bypass when PREFETCH_BYPASS_EN is defined.
module fetch_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_instr,
    output logic [XLEN-1:0] deq_pc
);

    localparam int unsigned     CW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_ALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(PC_STEP - XLEN'(1));

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic            req_fire;
    logic            rsp_keep;
    logic            bypass;
    logic            fifo_valid;
    logic            push;
    logic            pop;

    // Dropped in-flight requests still hold credit, so the FIFO can never overflow.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = reset && !redirect && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = reset && imem_rsp_valid && !redirect && (drop == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = rsp_keep && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign fifo_valid = (count != '0) && !redirect;
    assign deq_valid  = fifo_valid || bypass;
    assign pop        = fifo_valid && deq_ready;
    assign push       = rsp_keep && !(bypass && deq_ready);

    always_comb begin
        deq_instr = XLEN'(NOP_INSTR);
        deq_pc    = '0;
        if (fifo_valid) begin
            deq_instr = head_instr;
            deq_pc    = head_pc;
        end else if (bypass) begin
            deq_instr = imem_rsp_data;
            deq_pc    = rsp_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
                rsp_pc   <= redirect_pc & ALIGN_MASK;
                // No request issues this cycle, so everything left in flight is stale.
                drop     <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_keep)
                    rsp_pc <= rsp_pc + PC_STEP;
                else if (imem_rsp_valid && (drop != '0))
                    drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_pc    (rsp_pc),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: a fixed-latency memory model,
// directed scenarios, and a monitor that checks every dequeued instruction.
module tb_fetch_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mreq_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        deq_valid;
    logic        deq_ready      = 1'b1;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;

    exp_t        sb[$];
    mreq_t       pipe[$];
    int unsigned cyc     = 0;
    int unsigned lat     = 1;
    int unsigned req_cnt = 0;
    int unsigned pops    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    fetch_prefetch_queue #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    // Asserts reset mid-activity, checks the reset values, then releases it so the
    // caller resumes in the first cycle after release.
    task automatic apply_reset(input int unsigned l, input logic dr);
        step();
        reset          = 1'b0;
        lat            = l;
        deq_ready      = dr;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        samp();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_deq_instr", deq_instr, NOP);
        chk("rst_deq_pc",    deq_pc, 32'h0);
        sb.delete();
        step();
        reset = 1'b1;
    endtask

    // Memory: accepts when ready, answers in order after lat cycles.
    always @(posedge clock) begin
        mreq_t m;
        if (!reset) begin
            pipe.delete();
            req_cnt = 0;
        end else begin
            if (imem_rsp_valid)
                void'(pipe.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                m.due  = cyc + lat;
                m.addr = imem_req_addr;
                pipe.push_back(m);
                req_cnt++;
            end
        end
        cyc++;
        #1;
        if (reset && pipe.size() > 0 && pipe[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pipe[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Monitor: every handshake at decode must match the next expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            pops = 0;
        end else if (deq_valid && deq_ready) begin
            pops++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deq_unexpected: got pc %h instr %h, expected no instruction", deq_pc, deq_instr);
            end else begin
                e = sb.pop_front();
                chk("deq_pc",    deq_pc, e.pc);
                chk("deq_instr", deq_instr, e.instr);
            end
        end
    end

    initial begin
        // Streaming, latency 1, decode always ready.
        apply_reset(1, 1'b1);
        expect_run(32'h0, 32);
        samp();
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr",  imem_req_addr, 32'h0);
        step(); samp();
        chk("t1_c1_deq_valid", 32'(deq_valid), 32'(BYP));
        step(); samp();
        chk("t1_c2_deq_valid", 32'(deq_valid), 32'd1);
        chk("t1_c2_deq_pc",    deq_pc, BYP ? 32'h4 : 32'h0);
        repeat (10) step();
        deq_ready = 1'b0;
        samp();
        chk("t1_pops",    pops, BYP ? 32'd11 : 32'd10);
        chk("t1_req_cnt", req_cnt, 32'd12);

        // Decode stalled: the queue fills and stops issuing at DEPTH.
        apply_reset(1, 1'b0);
        expect_run(32'h0, 32);
        repeat (8) step();
        samp();
        chk("t2_req_cnt",   req_cnt, 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_deq_valid", 32'(deq_valid), 32'd1);
        chk("t2_deq_pc",    deq_pc, 32'h0);
        step();
        deq_ready = 1'b1;
        samp();
        chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        step(); samp();
        chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr",  imem_req_addr, 32'h10);
        repeat (10) step();
        deq_ready = 1'b0;

        // Memory back-pressure for 3 cycles while 0x8 is pending.
        apply_reset(1, 1'b1);
        expect_run(32'h0, 32);
        step();
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("t3_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_hold_addr",  imem_req_addr, 32'h8);
            step();
        end
        imem_req_ready = 1'b1;
        samp();
        chk("t3_c5_deq_valid", 32'(deq_valid), 32'd0);
        chk("t3_c5_deq_instr", deq_instr, NOP);
        step();
        step(); samp();
        chk("t3_c7_deq_pc", deq_pc, BYP ? 32'hC : 32'h8);
        repeat (9) step();
        deq_ready = 1'b0;
        samp();
        chk("t3_pops", pops, BYP ? 32'd12 : 32'd11);

        // Latency 3, redirect to 0x100 with two requests in flight.
        apply_reset(3, 1'b1);
        expect_run(32'h100, 32);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        samp();
        chk("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t4_redir_deq_valid", 32'(deq_valid), 32'd0);
        step();
        redirect = 1'b0;
        samp();
        chk("t4_target_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_target_addr",  imem_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_stale_valid", 32'(deq_valid), 32'd0);
            step(); samp();
        end
        chk("t4_c6_deq_valid", 32'(deq_valid), 32'(BYP));
        step(); samp();
        chk("t4_c7_deq_valid", 32'(deq_valid), 32'd1);
        chk("t4_c7_deq_pc",    deq_pc, BYP ? 32'h104 : 32'h100);
        repeat (6) step();
        deq_ready = 1'b0;

        // Unaligned redirect coinciding with a response and a ready decode.
        apply_reset(1, 1'b1);
        if (BYP)
            expect_run(32'h0, 1);
        expect_run(32'h100, 32);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        samp();
        chk("t5_redir_rsp_seen",  32'(imem_rsp_valid), 32'd1);
        chk("t5_redir_deq_valid", 32'(deq_valid), 32'd0);
        chk("t5_redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect = 1'b0;
        samp();
        chk("t5_target_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_target_addr",  imem_req_addr, 32'h100);
        repeat (7) step();
        deq_ready = 1'b0;
        samp();
        chk("t5_pops", pops, BYP ? 32'd7 : 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
